eth_rx: RTL

- 10BASE-T receive path, the counterpart of the team's eth_tx block.
- Oversamples the Manchester-encoded receive line, recovers bit timing, finds the preamble and SFD, and emits frame bytes LSB-first-assembled.
- Checks the Ethernet FCS (CRC32) and tracks link integrity from NLPs and frame activity.
- Sits between the line receiver pin and the packet sink (packet buffer / UDP filter).

---
 rtl/eth_pkg.sv | 21 ++
 rtl/eth_rx_manchester_dec.sv | 79 +++++++
 rtl/eth_rx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the 10BASE-T receive/transmit blocks.
package eth_pkg;

   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
   localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
   localparam logic [7:0]  SFD           = 8'hD5;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } rx_state_t;

   // One bit of the MSB-first CRC32 shift, same form as the transmitter uses.
   function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic din);
      crc_step = {crc[30:0], 1'b0} ^ (((din ^ crc[31]) == 1'b1) ? CRC_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/eth_rx_manchester_dec.sv
// Manchester decoder: synchronizes the rx pin, finds mid-bit transitions,
// and flags carrier loss and isolated short pulses (NLPs).
module eth_manchester_dec #(
   parameter int   SPB       = 8,
   parameter logic RX_INVERT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic bit_valid,
   output logic bit_value,
   output logic carrier_lost,
   output logic short_pulse
);

   localparam int SW = $clog2(2 * SPB + 1);
   localparam logic [SW-1:0] MID_MIN = SW'(3 * SPB / 4);
   localparam logic [SW-1:0] LOSS    = SW'(3 * SPB / 2);
   localparam logic [SW-1:0] SAT     = SW'(2 * SPB);
   localparam logic [SW-1:0] PULSE   = SW'(SPB);

   logic          sync1, sync2, prev_line;
   logic          line, trans, mid;
   logic [SW-1:0] since, since_inc;
   logic [SW-1:0] pw, pw_inc;
   logic          armed;

   // since_inc includes the current cycle, so it equals clk elapsed since the last mid-bit.
   always_comb begin
      line      = sync2 ^ RX_INVERT;
      trans     = line ^ prev_line;
      since_inc = (since == SAT) ? since : since + SW'(1);
      pw_inc    = (pw == SAT) ? pw : pw + SW'(1);
      mid       = trans && (since_inc >= MID_MIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1        <= RX_INVERT;
         sync2        <= RX_INVERT;
         prev_line    <= 1'b0;
         since        <= '0;
         pw           <= '0;
         armed        <= 1'b0;
         bit_valid    <= 1'b0;
         bit_value    <= 1'b0;
         carrier_lost <= 1'b0;
         short_pulse  <= 1'b0;
      end else begin
         sync1        <= rx;
         sync2        <= sync1;
         prev_line    <= line;
         bit_valid    <= mid;
         since        <= mid ? '0 : since_inc;
         carrier_lost <= !mid && (since_inc == LOSS);
         if (mid) begin
            bit_value <= line;
         end
         // An NLP is an edge out of a quiet line followed by a second edge within one bit time.
         if (trans && (since == SAT)) begin
            armed       <= 1'b1;
            pw          <= '0;
            short_pulse <= 1'b0;
         end else if (armed && trans) begin
            armed       <= 1'b0;
            short_pulse <= (pw_inc < PULSE);
         end else begin
            short_pulse <= 1'b0;
            if (armed) begin
               pw <= pw_inc;
               if (pw_inc >= PULSE) begin
                  armed <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/eth_rx.sv
// 10BASE-T receive path: frame FSM, byte assembly, FCS check and link timer
// on top of the Manchester decoder.
module eth_rx
   import eth_pkg::*;
#(
   parameter int   SPB          = 8,
   parameter logic RX_INVERT    = 1'b1,
   parameter int   MIN_BYTES    = 64,
   parameter int   MAX_BYTES    = 1518,
   parameter int   LINK_TIMEOUT = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_sof,
   output logic       rx_eof,
   output logic       rx_crc_ok,
   output logic       rx_err,
   output logic       link_ok
);

   localparam int CW = $clog2(MAX_BYTES + 1);
   localparam int TW = $clog2(LINK_TIMEOUT + 1);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_BYTES);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_BYTES);

   logic bit_valid, dec_bit, carrier_lost, short_pulse;

   eth_manchester_dec #(
      .SPB       (SPB),
      .RX_INVERT (RX_INVERT)
   ) u_dec (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .bit_valid    (bit_valid),
      .bit_value    (dec_bit),
      .carrier_lost (carrier_lost),
      .short_pulse  (short_pulse)
   );

   rx_state_t     state, state_next;
   logic          prev_bit, prev_bit_next;
   logic [7:0]    shreg, shreg_next, byte_shift;
   logic [2:0]    bit_cnt, bit_cnt_next;
   logic [CW-1:0] count, count_next;
   logic [31:0]   crc, crc_next;
   logic [7:0]    data_next;
   logic          valid_next, sof_next, eof_next, crc_ok_next, err_next;
   logic          frame_start;
   logic [TW-1:0] link_timer;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; all strobes are registered so they trail the decoded bit by one clk.
   always_comb begin
      state_next    = state;
      prev_bit_next = prev_bit;
      shreg_next    = shreg;
      bit_cnt_next  = bit_cnt;
      count_next    = count;
      crc_next      = crc;
      data_next     = rx_data;
      valid_next    = 1'b0;
      sof_next      = 1'b0;
      eof_next      = 1'b0;
      crc_ok_next   = 1'b0;
      err_next      = 1'b0;
      frame_start   = 1'b0;
      byte_shift    = {dec_bit, shreg[7:1]};

      case (state)
         IDLE: begin
            if (bit_valid) begin
               state_next    = PREAMBLE;
               prev_bit_next = dec_bit;
            end
         end
         PREAMBLE: begin
            if (carrier_lost) begin
               state_next = IDLE;
            end else if (bit_valid) begin
               prev_bit_next = dec_bit;
               if ({prev_bit, dec_bit} == SFD[7:6]) begin
                  state_next   = DATA;
                  bit_cnt_next = 3'd0;
                  count_next   = '0;
                  crc_next     = '1;
                  frame_start  = 1'b1;
               end
            end
         end
         DATA: begin
            if (carrier_lost) begin
               state_next  = IDLE;
               eof_next    = 1'b1;
               crc_ok_next = (crc == CRC_RESIDUE);
               err_next    = (bit_cnt != 3'd0) || (count < MIN_C);
            end else if (bit_valid) begin
               crc_next     = crc_step(crc, dec_bit);
               shreg_next   = byte_shift;
               bit_cnt_next = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (count == MAX_C) begin
                     state_next = DROP;
                     eof_next   = 1'b1;
                     err_next   = 1'b1;
                  end else begin
                     valid_next = 1'b1;
                     data_next  = byte_shift;
                     sof_next   = (count == '0);
                     count_next = count + CW'(1);
                  end
               end
            end
         end
         DROP: begin
            if (carrier_lost) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers and the link-integrity timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_bit   <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         count      <= '0;
         crc        <= '1;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_sof     <= 1'b0;
         rx_eof     <= 1'b0;
         rx_crc_ok  <= 1'b0;
         rx_err     <= 1'b0;
         link_timer <= '0;
      end else begin
         prev_bit  <= prev_bit_next;
         shreg     <= shreg_next;
         bit_cnt   <= bit_cnt_next;
         count     <= count_next;
         crc       <= crc_next;
         rx_data   <= data_next;
         rx_valid  <= valid_next;
         rx_sof    <= sof_next;
         rx_eof    <= eof_next;
         rx_crc_ok <= crc_ok_next;
         rx_err    <= err_next;
         if (frame_start || short_pulse) begin
            link_timer <= TW'(LINK_TIMEOUT);
         end else if (link_timer != '0) begin
            link_timer <= link_timer - TW'(1);
         end
      end
   end

   assign link_ok = (link_timer != '0);

endmodule
